fo_fi_initiator: RTL and testbench
==================================

// Module: fo_fi_initiator
// PURPOSE
// - MISTY1 FO function, 32-bit, built as the initiating side of the FI valid/ready protocol.
// - Accepts one FO request upstream, then issues three sequential FI requests (KI1..KI3) to an external FI instance.
// - Folds each FI result into the FO Feistel state and returns the 32-bit result.
// - Sits in the round datapath between key schedule and FL/round control; the FI core is instantiated by the parent.
// PARAMETERS
// - FI_DURATION  3  FI handshake-to-valid latency; used by assertions/bench only, RTL is latency-agnostic
// PORTS
// - clk          in   1   clock, all logic on rising edge
// - rst          in   1   reset, synchronous, active-high
// - enable_i     in   1   global enable; low freezes FSM; forwarded to FI
// - valid_i      in   1   FO request valid
// - ready_o      out  1   FO request ready (IDLE && enable_i)
// - plain_i      in   32  FO input; [31:16]=t0, [15:0]=t1
// - key_ko_i     in   64  {KO1,KO2,KO3,KO4}, KO1 at [63:48]
// - key_ki_i     in   48  {KI1,KI2,KI3}, KI1 at [47:32]
// - sypher_o     out  32  FO result {t1,t0}, held until next result
// - valid_o      out  1   one-cycle result strobe
// - fi_enable_o  out  1   = enable_i (combinational)
// - fi_valid_o   out  1   FI request valid
// - fi_ready_i   in   1   FI request ready
// - fi_plain_o   out  16  FI data input
// - fi_key_o     out  16  FI key input
// - fi_sypher_i  in   16  FI result
// - fi_valid_i   in   1   FI result strobe
// BEHAVIOUR
// - Reset (rst=1 at edge): state IDLE, round=0, t0/t1/key regs=0, sypher_o=0, valid_o=0, fi_valid_o=0.
// - FSM: IDLE -> ISSUE(r) -> WAIT(r) -> ... -> DONE -> IDLE, r in 0..2.
//   - IDLE: ready_o=enable_i; on valid_i&&ready_o latch t0,t1,KO,KI; r=0; -> ISSUE.
//   - ISSUE: fi_valid_o=enable_i; fi_plain_o=t_sel^KO[r]; fi_key_o=KI[r].
//     - t_sel = t0 for r=0,2; t1 for r=1.
//     - fi_plain_o/fi_key_o stable while fi_valid_o high and unacknowledged.
//     - On fi_valid_o&&fi_ready_i -> WAIT.
//   - WAIT: fi_valid_o=0; on fi_valid_i:
//     - r=0,2: t0 <= fi_sypher_i ^ t1.
//     - r=1: t1 <= fi_sypher_i ^ t0.
//     - r<2: r++, -> ISSUE; r=2: -> DONE.
//   - DONE: sypher_o <= {t1^KO4, t0}; valid_o=1 for exactly this cycle; -> IDLE.
// - Latency, FI always ready: input handshake edge = cycle 0, valid_o at cycle 4+3*FI_DURATION (13 at default).
// - Next request accepted the cycle after valid_o; no overlap, one FO in flight.
// - enable_i low:
//   - FSM holds state; ready_o=0, fi_valid_o=0, valid_o=0.
//   - In WAIT, fi_valid_i is still captured, so a result is never lost.
// - fi_valid_i outside WAIT is ignored (stale result after reset).
// - rst mid-operation: next edge -> IDLE, all outputs reset values, partial result discarded.
// - Arithmetic: XOR only, 16-bit, no carries; KO/KI slices fixed.
// STRUCTURE
// - FO_pkg:
//   - typedef enum {IDLE,ISSUE,WAIT,DONE} fo_state_t.
//   - localparams for KO/KI slice offsets.
//   - FI_DURATION default.
//   - function ko_sel(r)/ki_sel(r).
// - Sub-module fo_key_mux: combinational round-indexed KO/KI selection. FSM plus datapath stay in top.
// - Interface FO_intf mirrors FI_intf: upstream and FI-side signals, handshake/duration assertions.
// TESTING (bench uses FI stub, identity FI: sypher=plain, fixed DURATION=3)
// - plain=0x1234_5678, KO=0, KI=0 -> sypher_o=0x1234_5678, valid_o at cycle 13.
// - plain=0x1234_5678, KO=0x0001_0002_0003_0004, KI=0xAAAA_BBBB_CCCC:
//   - fi_plain_o seq 0x1235, 0x567A, 0x444E; fi_key_o 0xAAAA, 0xBBBB, 0xCCCC.
//   - sypher_o=0x1233_5679.
// - fi_ready_i held low 5 cycles during round 1 -> fi_plain_o/fi_key_o stable, result unchanged, latency +5.
// - enable_i low 4 cycles in WAIT(1) -> ready_o=0, fi_enable_o=0, no valid_o; result correct, latency +4.
// - rst pulsed in WAIT(2), then late fi_valid_i -> ignored; outputs 0; next request gives correct result.
// - Back-to-back requests, valid_i held high -> second accepted cycle after valid_o; both results correct.

Source files
------------

// File: rtl/fo_fi_initiator_pkg.sv
// Shared FSM encodings, key-slice offsets and round-indexed key selectors for the MISTY1 FO initiator.
package fo_fi_initiator_pkg;

   // Handshake-to-result latency of the FI core in the parent; the FO logic never depends on it.
   localparam int FI_DURATION = 3;

   typedef logic [1:0] fo_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] LAST_ROUND = 2'd2;

   localparam int KO1_LSB = 48;
   localparam int KO2_LSB = 32;
   localparam int KO3_LSB = 16;
   localparam int KO4_LSB = 0;

   localparam int KI1_LSB = 32;
   localparam int KI2_LSB = 16;
   localparam int KI3_LSB = 0;

   // Round r mixes KO(r+1) into the active half before the FI call.
   function automatic logic [15:0] ko_sel(input logic [63:0] ko, input logic [1:0] r);
      case (r)
         2'd0:    ko_sel = ko[KO1_LSB +: 16];
         2'd1:    ko_sel = ko[KO2_LSB +: 16];
         2'd2:    ko_sel = ko[KO3_LSB +: 16];
         default: ko_sel = ko[KO4_LSB +: 16];
      endcase
   endfunction

   function automatic logic [15:0] ki_sel(input logic [47:0] ki, input logic [1:0] r);
      case (r)
         2'd0:    ki_sel = ki[KI1_LSB +: 16];
         2'd1:    ki_sel = ki[KI2_LSB +: 16];
         2'd2:    ki_sel = ki[KI3_LSB +: 16];
         default: ki_sel = 16'h0000;
      endcase
   endfunction

   // Rounds 0 and 2 work on t0, round 1 on t1.
   function automatic logic round_uses_t0(input logic [1:0] r);
      round_uses_t0 = (r != 2'd1);
   endfunction

endpackage

// File: rtl/fo_fi_initiator_if.sv
// Upstream FO request/result and downstream FI request/result signals of the FO initiator.
interface fo_fi_initiator_if (
   input logic clk,
   input logic rst
);

   logic        enable_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] plain_i;
   logic [63:0] key_ko_i;
   logic [47:0] key_ki_i;
   logic [31:0] sypher_o;
   logic        valid_o;

   logic        fi_enable_o;
   logic        fi_valid_o;
   logic        fi_ready_i;
   logic [15:0] fi_plain_o;
   logic [15:0] fi_key_o;
   logic [15:0] fi_sypher_i;
   logic        fi_valid_i;

   // FO initiator side.
   modport slave (
      input  enable_i, valid_i, plain_i, key_ko_i, key_ki_i,
      input  fi_ready_i, fi_sypher_i, fi_valid_i,
      output ready_o, sypher_o, valid_o,
      output fi_enable_o, fi_valid_o, fi_plain_o, fi_key_o
   );

   // Environment side: FO requester plus the FI core.
   modport master (
      output enable_i, valid_i, plain_i, key_ko_i, key_ki_i,
      output fi_ready_i, fi_sypher_i, fi_valid_i,
      input  ready_o, sypher_o, valid_o,
      input  fi_enable_o, fi_valid_o, fi_plain_o, fi_key_o
   );

   // A stalled FI request must present the same operands until accepted.
   a_fi_req_hold: assert property (@(posedge clk) disable iff (rst)
      (fi_valid_o && !fi_ready_i) |=> ($stable(fi_plain_o) && $stable(fi_key_o)));

   a_valid_pulse: assert property (@(posedge clk) disable iff (rst)
      valid_o |=> !valid_o);

   a_one_in_flight: assert property (@(posedge clk) disable iff (rst)
      !(ready_o && fi_valid_o));

   a_enable_fwd: assert property (@(posedge clk)
      fi_enable_o == enable_i);

endinterface

// File: rtl/fo_fi_initiator_key_mux.sv
// Round-indexed KO/KI selection; purely combinational.
module fo_fi_initiator_key_mux
   import fo_fi_initiator_pkg::*;
(
   input  logic [63:0] key_ko,
   input  logic [47:0] key_ki,
   input  logic [1:0]  round,
   output logic [15:0] ko_r,
   output logic [15:0] ki_r,
   output logic [15:0] ko4
);

   assign ko_r = ko_sel(key_ko, round);
   assign ki_r = ki_sel(key_ki, round);
   assign ko4  = key_ko[KO4_LSB +: 16];

endmodule

// File: rtl/fo_fi_initiator.sv
// MISTY1 FO over an external FI core; result 4+3*FI latency cycles after the request handshake.
// Backpressure: ready_o only while idle and enabled; an FI request is held until fi_ready_i.
module fo_fi_initiator
   import fo_fi_initiator_pkg::*;
(
   input logic              clk,
   input logic              rst,
   fo_fi_initiator_if.slave bus
);

   fo_state_t   state;
   logic [1:0]  round;
   logic [15:0] t0;
   logic [15:0] t1;
   logic [63:0] ko_q;
   logic [47:0] ki_q;
   logic        res_got;

   logic [15:0] ko_r;
   logic [15:0] ki_r;
   logic [15:0] ko4;
   logic [15:0] t_sel;
   logic        fo_hs;
   logic        fi_hs;
   logic        res_avail;

   fo_fi_initiator_key_mux u_key_mux (
      .key_ko (ko_q),
      .key_ki (ki_q),
      .round  (round),
      .ko_r   (ko_r),
      .ki_r   (ki_r),
      .ko4    (ko4)
   );

   always_comb begin
      t_sel = round_uses_t0(round) ? t0 : t1;
   end

   assign bus.fi_enable_o = bus.enable_i;
   assign bus.ready_o     = (state == ST_IDLE)  && bus.enable_i;
   assign bus.fi_valid_o  = (state == ST_ISSUE) && bus.enable_i;
   assign bus.fi_plain_o  = t_sel ^ ko_r;
   assign bus.fi_key_o    = ki_r;

   assign fo_hs     = bus.valid_i && bus.ready_o;
   assign fi_hs     = bus.fi_valid_o && bus.fi_ready_i;
   // A result that lands while disabled is remembered so the round can advance once re-enabled.
   assign res_avail = bus.fi_valid_i || res_got;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         round        <= 2'd0;
         t0           <= 16'h0000;
         t1           <= 16'h0000;
         ko_q         <= 64'h0;
         ki_q         <= 48'h0;
         res_got      <= 1'b0;
         bus.sypher_o <= 32'h0;
         bus.valid_o  <= 1'b0;
      end else begin
         bus.valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fo_hs) begin
                  t0    <= bus.plain_i[31:16];
                  t1    <= bus.plain_i[15:0];
                  ko_q  <= bus.key_ko_i;
                  ki_q  <= bus.key_ki_i;
                  round <= 2'd0;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (fi_hs) begin
                  res_got <= 1'b0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.fi_valid_i) begin
                  if (round_uses_t0(round)) begin
                     t0 <= bus.fi_sypher_i ^ t1;
                  end else begin
                     t1 <= bus.fi_sypher_i ^ t0;
                  end
               end
               if (bus.enable_i && res_avail) begin
                  res_got <= 1'b0;
                  if (round == LAST_ROUND) begin
                     state <= ST_DONE;
                  end else begin
                     round <= round + 2'd1;
                     state <= ST_ISSUE;
                  end
               end else if (bus.fi_valid_i) begin
                  res_got <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.enable_i) begin
                  bus.sypher_o <= {t1 ^ ko4, t0};
                  bus.valid_o  <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fo_fi_initiator.sv
// Bench for fo_fi_initiator with an identity FI stub of fixed duration.
module tb_fo_fi_initiator;
   import fo_fi_initiator_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fo_fi_initiator_if bus (.clk(clk), .rst(rst));

   fo_fi_initiator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- FI stub: identity, FI_DURATION cycles, frozen while disabled
   int          fi_cnt = 0;
   logic [15:0] fi_cap = 16'h0;
   int          hs_count = 0;
   int          fired_count = 0;
   logic [15:0] plain_log[$];
   logic [15:0] key_log[$];

   always @(negedge clk) begin
      bus.fi_valid_i = 1'b0;
      if (fi_cnt > 0 && bus.fi_enable_o) begin
         fi_cnt = fi_cnt - 1;
         if (fi_cnt == 0) begin
            bus.fi_valid_i  = 1'b1;
            bus.fi_sypher_i = fi_cap;
            fired_count     = fired_count + 1;
         end
      end
      if (bus.fi_valid_o && bus.fi_ready_i) begin
         fi_cap = bus.fi_plain_o;
         fi_cnt = FI_DURATION;
         plain_log.push_back(bus.fi_plain_o);
         key_log.push_back(bus.fi_key_o);
         hs_count = hs_count + 1;
      end
   end

   // ---------------- reference model: textbook FO with identity FI
   function automatic logic [15:0] fi_ref(input logic [15:0] x);
      return x;
   endfunction

   task automatic fo_ref(input logic [31:0] p, input logic [63:0] ko, input logic [47:0] ki,
                         output logic [31:0] res, output logic [47:0] fin);
      logic [15:0] t[2];
      logic [15:0] kos[4];
      logic [15:0] x;
      int          a;
      t[0] = p[31:16];
      t[1] = p[15:0];
      for (int k = 0; k < 4; k++) kos[k] = ko[63-16*k -: 16];
      fin = '0;
      for (int r = 0; r < 3; r++) begin
         a = r % 2;
         x = t[a] ^ kos[r];
         fin[47-16*r -: 16] = x;
         t[a] = fi_ref(x) ^ t[1-a];
      end
      res = {t[1] ^ kos[3], t[0]};
      if (ki === 48'hx) res = 'x;
   endtask

   // ---------------- request driver with optional disturbances
   int          stall_cfg = 0;
   int          en_gap_cfg = 0;
   int          stall_seen, stall_diff, gap_seen, gap_bad;
   logic [15:0] stall_plain, stall_key;

   task automatic run_fo(input logic [31:0] p, input logic [63:0] ko, input logic [47:0] ki,
                         input bit chain, input logic [31:0] np, input logic [63:0] nko,
                         input logic [47:0] nki, output logic [31:0] res,
                         output int hs_edge, output int done_edge, output bit ok);
      int base;
      bit stall_on;
      int gap_left;
      if (!bus.valid_i) begin
         @(posedge clk); #1;
         bus.valid_i  = 1'b1;
         bus.plain_i  = p;
         bus.key_ko_i = ko;
         bus.key_ki_i = ki;
         @(negedge clk); #1;
      end
      base = hs_count; hs_edge = -1; done_edge = -1; ok = 1'b0; res = '0;
      stall_seen = 0; stall_diff = 0; gap_seen = 0; gap_bad = 0;
      stall_on = 1'b0; gap_left = -1;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (hs_edge < 0) begin
            if (bus.valid_i && bus.ready_o) hs_edge = cyc + 1;
         end else if (bus.valid_o) begin
            ok = 1'b1; res = bus.sypher_o; done_edge = cyc;
         end
         if (stall_on && bus.fi_valid_o && !bus.fi_ready_i) begin
            if (stall_seen == 0) begin
               stall_plain = bus.fi_plain_o; stall_key = bus.fi_key_o;
            end else if (bus.fi_plain_o !== stall_plain || bus.fi_key_o !== stall_key) begin
               stall_diff++;
            end
            stall_seen++;
         end
         if (gap_left > 0) begin
            gap_seen++;
            if (bus.ready_o || bus.fi_enable_o || bus.valid_o || bus.fi_valid_o) gap_bad++;
         end
         if (!ok) begin
            @(posedge clk); #1;
            if (hs_edge >= 0 && cyc == hs_edge) begin
               if (chain) begin
                  bus.plain_i = np; bus.key_ko_i = nko; bus.key_ki_i = nki;
               end else begin
                  bus.valid_i = 1'b0;
               end
            end
            if (stall_cfg > 0 && !stall_on && hs_count - base == 1) begin
               bus.fi_ready_i = 1'b0; stall_on = 1'b1;
            end else if (stall_on && stall_seen >= stall_cfg) begin
               bus.fi_ready_i = 1'b1;
            end
            if (en_gap_cfg > 0 && gap_left < 0 && hs_count - base == 2) begin
               bus.enable_i = 1'b0; gap_left = en_gap_cfg;
            end else if (gap_left > 0) begin
               gap_left--;
               if (gap_left == 0) bus.enable_i = 1'b1;
            end
            @(negedge clk); #1;
         end
      end
      bus.fi_ready_i = 1'b1;
      bus.enable_i   = 1'b1;
   endtask

   // ---------------- tests
   task automatic test_reset();
      bus.enable_i = 1'b1; bus.valid_i = 1'b0; bus.plain_i = '0;
      bus.key_ko_i = '0; bus.key_ki_i = '0; bus.fi_ready_i = 1'b1;
      bus.fi_valid_i = 1'b0; bus.fi_sypher_i = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready_o); end
      total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
      total++; if (bus.sypher_o !== 32'h0) begin bad++; $display("FAIL reset_sypher got=%h want=0", bus.sypher_o); end
      total++; if (bus.fi_valid_o !== 1'b0) begin bad++; $display("FAIL reset_fi_valid got=%b want=0", bus.fi_valid_o); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_zero_keys();
      logic [31:0] res; int hs, dn; bit ok;
      run_fo(32'h1234_5678, 64'h0, 48'h0, 1'b0, '0, '0, '0, res, hs, dn, ok);
      total++; if (!ok || res !== 32'h1234_5678) begin bad++; $display("FAIL zero_keys_result got=%h want=12345678 done=%0b", res, ok); end
      total++; if (!ok || dn - hs != 4 + 3*FI_DURATION) begin bad++; $display("FAIL zero_keys_latency got=%0d want=%0d", dn - hs, 4 + 3*FI_DURATION); end
   endtask

   task automatic test_key_seq();
      logic [31:0] res; int hs, dn, idx; bit ok;
      logic [15:0] ep[3];
      logic [15:0] ek[3];
      ep[0] = 16'h1235; ep[1] = 16'h567A; ep[2] = 16'h444E;
      ek[0] = 16'hAAAA; ek[1] = 16'hBBBB; ek[2] = 16'hCCCC;
      idx = plain_log.size();
      run_fo(32'h1234_5678, 64'h0001_0002_0003_0004, 48'hAAAA_BBBB_CCCC, 1'b0, '0, '0, '0, res, hs, dn, ok);
      total++; if (!ok || res !== 32'h1233_5679) begin bad++; $display("FAIL key_seq_result got=%h want=12335679", res); end
      total++; if (!ok || dn - hs != 13) begin bad++; $display("FAIL key_seq_latency got=%0d want=13", dn - hs); end
      for (int r = 0; r < 3; r++) begin
         total++;
         if (plain_log.size() <= idx + r || plain_log[idx+r] !== ep[r] || key_log[idx+r] !== ek[r]) begin
            bad++;
            $display("FAIL key_seq_fi_req r=%0d got=%h/%h want=%h/%h", r,
                     (plain_log.size() > idx + r) ? plain_log[idx+r] : 16'hxxxx,
                     (key_log.size() > idx + r) ? key_log[idx+r] : 16'hxxxx, ep[r], ek[r]);
         end
      end
   endtask

   task automatic test_fi_stall();
      logic [31:0] p, res, exp; logic [63:0] ko; logic [47:0] ki, fin; int hs, dn; bit ok;
      p = $urandom; ko = {$urandom, $urandom}; ki = 48'h1357_9BDF_2468;
      fo_ref(p, ko, ki, exp, fin);
      stall_cfg = 5;
      run_fo(p, ko, ki, 1'b0, '0, '0, '0, res, hs, dn, ok);
      stall_cfg = 0;
      total++; if (!ok || res !== exp) begin bad++; $display("FAIL stall_result got=%h want=%h", res, exp); end
      total++; if (!ok || dn - hs != 18) begin bad++; $display("FAIL stall_latency got=%0d want=18", dn - hs); end
      total++; if (stall_seen != 5) begin bad++; $display("FAIL stall_cycles got=%0d want=5", stall_seen); end
      total++; if (stall_diff != 0) begin bad++; $display("FAIL stall_operands_moved got=%0d want=0", stall_diff); end
      total++; if (stall_plain !== fin[31:16] || stall_key !== ki[31:16]) begin
         bad++; $display("FAIL stall_operands got=%h/%h want=%h/%h", stall_plain, stall_key, fin[31:16], ki[31:16]);
      end
   endtask

   task automatic test_enable_gap();
      logic [31:0] p, res, exp; logic [63:0] ko; logic [47:0] ki, fin; int hs, dn; bit ok;
      p = $urandom; ko = {$urandom, $urandom}; ki = 48'hFEDC_BA98_7654;
      fo_ref(p, ko, ki, exp, fin);
      en_gap_cfg = 4;
      run_fo(p, ko, ki, 1'b0, '0, '0, '0, res, hs, dn, ok);
      en_gap_cfg = 0;
      total++; if (!ok || res !== exp) begin bad++; $display("FAIL enable_gap_result got=%h want=%h", res, exp); end
      total++; if (!ok || dn - hs != 17) begin bad++; $display("FAIL enable_gap_latency got=%0d want=17", dn - hs); end
      total++; if (gap_seen != 4 || gap_bad != 0) begin bad++; $display("FAIL enable_gap_outputs cycles=%0d active=%0d want 4/0", gap_seen, gap_bad); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res, exp; logic [47:0] fin; int hs, dn, base, fc, obad; bit ok, seen;
      base = hs_count; seen = 1'b0; obad = 0;
      @(posedge clk); #1;
      bus.valid_i = 1'b1; bus.plain_i = 32'hDEAD_BEEF; bus.key_ko_i = 64'h1111_2222_3333_4444; bus.key_ki_i = 48'h5555_6666_7777;
      for (int i = 0; i < 200 && hs_count - base < 3; i++) begin
         @(negedge clk); #1;
         if (bus.valid_i && bus.ready_o) seen = 1'b1;
         @(posedge clk); #1;
         if (seen) bus.valid_i = 1'b0;
      end
      total++; if (hs_count - base != 3) begin bad++; $display("FAIL rst_mid_reach_round2 got=%0d want=3", hs_count - base); end
      @(posedge clk); #1;
      rst = 1'b1; fc = fired_count;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         if (bus.valid_o !== 1'b0 || bus.sypher_o !== 32'h0 || bus.fi_valid_o !== 1'b0 || bus.ready_o !== 1'b1) obad++;
      end
      total++; if (fired_count - fc != 1) begin bad++; $display("FAIL rst_mid_stale_result got=%0d want=1", fired_count - fc); end
      total++; if (obad != 0) begin bad++; $display("FAIL rst_mid_outputs got=%0d want=0 bad cycles", obad); end
      fo_ref(32'hCAFE_F00D, 64'h0F0F_F0F0_00FF_FF00, 48'h0123_4567_89AB, exp, fin);
      run_fo(32'hCAFE_F00D, 64'h0F0F_F0F0_00FF_FF00, 48'h0123_4567_89AB, 1'b0, '0, '0, '0, res, hs, dn, ok);
      total++; if (!ok || res !== exp) begin bad++; $display("FAIL rst_mid_next_result got=%h want=%h", res, exp); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] p1, p2, r1, r2, e1, e2; logic [63:0] k1, k2; logic [47:0] i1, i2, fin, w;
      int hs1, dn1, hs2, dn2; bit ok1, ok2; logic [31:0] a, b;
      p1 = $urandom; p2 = $urandom; k1 = {$urandom, $urandom}; k2 = {$urandom, $urandom};
      a = $urandom; b = $urandom; w = {a[15:0], b}; i1 = w;
      a = $urandom; b = $urandom; w = {a[15:0], b}; i2 = w;
      fo_ref(p1, k1, i1, e1, fin);
      fo_ref(p2, k2, i2, e2, fin);
      run_fo(p1, k1, i1, 1'b1, p2, k2, i2, r1, hs1, dn1, ok1);
      run_fo(p2, k2, i2, 1'b0, '0, '0, '0, r2, hs2, dn2, ok2);
      total++; if (!ok1 || r1 !== e1) begin bad++; $display("FAIL b2b_first got=%h want=%h", r1, e1); end
      total++; if (!ok2 || r2 !== e2) begin bad++; $display("FAIL b2b_second got=%h want=%h", r2, e2); end
      total++; if (!ok1 || !ok2 || hs2 != dn1 + 1) begin bad++; $display("FAIL b2b_accept_edge got=%0d want=%0d", hs2, dn1 + 1); end
   endtask

   task automatic test_random();
      logic [31:0] p, res, exp, a, b; logic [63:0] ko; logic [47:0] ki, fin, got_p, got_k; int hs, dn, idx; bit ok;
      for (int n = 0; n < 6; n++) begin
         p = $urandom; ko = {$urandom, $urandom};
         a = $urandom; b = $urandom; ki = {a[15:0], b};
         fo_ref(p, ko, ki, exp, fin);
         idx = plain_log.size();
         run_fo(p, ko, ki, 1'b0, '0, '0, '0, res, hs, dn, ok);
         got_p = 'x; got_k = 'x;
         if (plain_log.size() >= idx + 3) begin
            got_p = {plain_log[idx], plain_log[idx+1], plain_log[idx+2]};
            got_k = {key_log[idx], key_log[idx+1], key_log[idx+2]};
         end
         total++; if (!ok || res !== exp) begin bad++; $display("FAIL rand%0d_result got=%h want=%h", n, res, exp); end
         total++; if (!ok || dn - hs != 13) begin bad++; $display("FAIL rand%0d_latency got=%0d want=13", n, dn - hs); end
         total++; if (got_p !== fin) begin bad++; $display("FAIL rand%0d_fi_plain got=%h want=%h", n, got_p, fin); end
         total++; if (got_k !== ki) begin bad++; $display("FAIL rand%0d_fi_key got=%h want=%h", n, got_k, ki); end
      end
   endtask

   initial begin
      test_reset();
      test_zero_keys();
      test_key_seq();
      test_fi_stall();
      test_enable_gap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
